// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types for the cache-to-RAM arbiter.
package mem_arbiter_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
    typedef enum logic [1:0] {IDLE, ISERV, DSERV} arb_state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: icache, dcache and RAM port bundle seen by the arbiter.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;
    logic iREN, iwait, dREN, dWEN, dwait, ramREN, ramWEN, err;
    word_t iaddr, iload, daddr, dstore, dload, ramaddr, ramstore, ramload;
    logic [1:0] ramstate;
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises icache reads and dcache reads/writes onto one RAM port.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    arb_state_t r_state, w_next;
    logic r_last_d, r_wen, r_err;
    word_t r_addr, r_data, w_rdata;
    logic [CW-1:0] r_cnt;
    logic w_serv, w_abort, w_done, w_tmo, w_fin, w_grant_d, w_grant_i;
    ramstate_t w_rs;
    always_comb begin
        w_rs      = ramstate_t'(bus.ramstate);
        w_serv    = r_state != IDLE;
        // A client that withdraws or redirects its request cancels the access silently
        w_abort   = r_state == ISERV ? (!bus.iREN || bus.iaddr != r_addr) :
                    r_state == DSERV ? (!(bus.dREN || bus.dWEN) || bus.dWEN != r_wen || bus.daddr != r_addr) : 1'b0;
        w_done    = w_serv && !w_abort && (w_rs == ACCESS || w_rs == ERROR);
        w_tmo     = w_serv && !w_abort && !w_done && r_cnt == CW'(TIMEOUT - 1);
        w_fin     = w_done || w_tmo;
        w_grant_d = r_state == IDLE && (bus.dREN || bus.dWEN) && !(bus.iREN && r_last_d);
        w_grant_i = r_state == IDLE && bus.iREN && !w_grant_d;
        w_next    = w_grant_d ? DSERV : w_grant_i ? ISERV : (w_abort || w_fin) ? IDLE : r_state;
        w_rdata   = w_done && !r_wen ? bus.ramload : '0;
        bus.iwait    = !(w_fin && r_state == ISERV);
        bus.dwait    = !(w_fin && r_state == DSERV);
        bus.iload    = r_state == ISERV ? w_rdata : '0;
        bus.dload    = r_state == DSERV ? w_rdata : '0;
        bus.ramREN   = w_serv && !r_wen;
        bus.ramWEN   = w_serv && r_wen;
        bus.ramaddr  = w_serv ? r_addr : '0;
        bus.ramstore = w_serv ? r_data : '0;
        bus.err      = r_err;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= IDLE;
            r_last_d <= 1'b0;
            r_wen    <= 1'b0;
            r_err    <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant_d) begin
                r_addr <= bus.daddr;
                r_data <= bus.dstore;
                r_wen  <= bus.dWEN;
                r_cnt  <= '0;
            end else if (w_grant_i) begin
                r_addr <= bus.iaddr;
                r_data <= '0;
                r_wen  <= 1'b0;
                r_cnt  <= '0;
            end else if (w_serv && r_cnt != CW'(TIMEOUT)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_fin) r_last_d <= r_state == DSERV;
            if ((w_done && w_rs == ERROR) || w_tmo) r_err <= 1'b1;
        end
    end
endmodule
